// File: rtl/crg_reset_sequencer.sv
// crg_reset_sequencer: sequences the PLL reset pulse, lock qualification and SoC
// reset release, all on the board clock CLK12M. A lock timeout or lock loss restarts
// the sequence and bumps a saturating retry counter.
// Optional push-button SoC reset (no PLL reset): define CRG_EXT_RESET_EN.
module crg_reset_sequencer #(
  parameter int unsigned PLL_RST_CYCLES     = 16,
  parameter int unsigned LOCK_TIMEOUT       = 65535,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned HOLD_CYCLES        = 64
) (
  input  logic       CLK12M,
  input  logic       reset,
  input  logic       lock_pll,
`ifdef CRG_EXT_RESET_EN
  input  logic       ext_reset_n,
`endif
  output logic       pll_areset,
  output logic       soc_reset,
  output logic       running,
  output logic [2:0] state,
  output logic [3:0] retry_cnt
);

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    HOLD      = 3'd3,
`ifdef CRG_EXT_RESET_EN
    BTN_HOLD  = 3'd5,
`endif
    RUN       = 3'd4
  } state_t;

  localparam logic [15:0] PLL_RST_LOAD = 16'(PLL_RST_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LOAD = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] STABLE_LOAD  = 16'(LOCK_STABLE_CYCLES - 1);
  localparam logic [15:0] HOLD_LOAD    = 16'(HOLD_CYCLES - 1);

  state_t      cur_state, nxt_state;
  logic [15:0] cnt, cnt_nxt;
  logic        retry_inc;
  logic        lock_meta, lock_s;

  assign state = cur_state;

  // Two-flop synchroniser for the asynchronous PLL lock
  always_ff @(posedge CLK12M or posedge reset) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= lock_pll;
      lock_s    <= lock_meta;
    end
  end

`ifdef CRG_EXT_RESET_EN
  logic       btn_meta, btn_sync, btn;
  logic [1:0] btn_hist;

  // Button synchroniser plus 3-sample debounce; btn flips only on 3 equal samples
  always_ff @(posedge CLK12M or posedge reset) begin
    if (reset) begin
      btn_meta <= 1'b1;
      btn_sync <= 1'b1;
      btn_hist <= 2'b11;
      btn      <= 1'b0;
    end else begin
      btn_meta <= ext_reset_n;
      btn_sync <= btn_meta;
      btn_hist <= {btn_hist[0], btn_sync};
      if ({btn_hist, btn_sync} == 3'b000)
        btn <= 1'b1;
      else if ({btn_hist, btn_sync} == 3'b111)
        btn <= 1'b0;
    end
  end
`endif

  // Next-state, counter reload and retry request; lock events beat the counter
  always_comb begin
    nxt_state = cur_state;
    cnt_nxt   = (cnt == '0) ? '0 : cnt - 16'd1;
    retry_inc = 1'b0;
    case (cur_state)
      PLL_RST: begin
        if (cnt == '0) begin
          nxt_state = WAIT_LOCK;
          cnt_nxt   = TIMEOUT_LOAD;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          nxt_state = STABLE;
          cnt_nxt   = STABLE_LOAD;
        end else if (cnt == '0) begin
          nxt_state = PLL_RST;
          cnt_nxt   = PLL_RST_LOAD;
          retry_inc = 1'b1;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          nxt_state = WAIT_LOCK;
          cnt_nxt   = TIMEOUT_LOAD;
        end else if (cnt == '0) begin
          nxt_state = HOLD;
          cnt_nxt   = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (!lock_s) begin
          nxt_state = PLL_RST;
          cnt_nxt   = PLL_RST_LOAD;
          retry_inc = 1'b1;
        end else if (cnt == '0) begin
          nxt_state = RUN;
        end
      end
      RUN: begin
        if (!lock_s) begin
          nxt_state = PLL_RST;
          cnt_nxt   = PLL_RST_LOAD;
          retry_inc = 1'b1;
        end
`ifdef CRG_EXT_RESET_EN
        else if (btn) begin
          nxt_state = BTN_HOLD;
        end
`endif
      end
`ifdef CRG_EXT_RESET_EN
      BTN_HOLD: begin
        if (!lock_s) begin
          nxt_state = PLL_RST;
          cnt_nxt   = PLL_RST_LOAD;
          retry_inc = 1'b1;
        end else if (!btn) begin
          nxt_state = HOLD;
          cnt_nxt   = HOLD_LOAD;
        end
      end
`endif
      default: begin
        nxt_state = PLL_RST;
        cnt_nxt   = PLL_RST_LOAD;
      end
    endcase
  end

  // State, counter and outputs share one register stage; outputs decode nxt_state
  always_ff @(posedge CLK12M or posedge reset) begin
    if (reset) begin
      cur_state  <= PLL_RST;
      cnt        <= PLL_RST_LOAD;
      pll_areset <= 1'b1;
      soc_reset  <= 1'b1;
      running    <= 1'b0;
      retry_cnt  <= '0;
    end else begin
      cur_state  <= nxt_state;
      cnt        <= cnt_nxt;
      pll_areset <= (nxt_state == PLL_RST);
      soc_reset  <= (nxt_state != RUN);
      running    <= (nxt_state == RUN);
      if (retry_inc && retry_cnt != 4'hF)
        retry_cnt <= retry_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_crg_reset_sequencer.sv
// tb_crg_reset_sequencer: self-checking bench for crg_reset_sequencer with a
// phase/elapsed-time reference model and directed latency checks.
module tb_crg_reset_sequencer;

  localparam int PRC = 16;
  localparam int LT  = 100;
  localparam int LSC = 8;
  localparam int HC  = 4;

  logic       CLK12M = 1'b0;
  logic       reset  = 1'b1;
  logic       lock_pll = 1'b0;
  logic       pll_areset, soc_reset, running;
  logic [2:0] state;
  logic [3:0] retry_cnt;
`ifdef CRG_EXT_RESET_EN
  logic       ext_reset_n = 1'b1;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  crg_reset_sequencer #(
    .PLL_RST_CYCLES(PRC),
    .LOCK_TIMEOUT(LT),
    .LOCK_STABLE_CYCLES(LSC),
    .HOLD_CYCLES(HC)
  ) dut (
    .CLK12M(CLK12M),
    .reset(reset),
    .lock_pll(lock_pll),
`ifdef CRG_EXT_RESET_EN
    .ext_reset_n(ext_reset_n),
`endif
    .pll_areset(pll_areset),
    .soc_reset(soc_reset),
    .running(running),
    .state(state),
    .retry_cnt(retry_cnt)
  );

  always #5 CLK12M = ~CLK12M;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // m_ph: 0 pll reset, 1 wait lock, 2 stable, 3 hold, 4 run, 5 button hold
  // m_el: edges spent in the current phase since entry
  int m_ph, m_el, m_retry;
  bit lq[$];        // raw lock samples of the previous two edges, oldest first
`ifdef CRG_EXT_RESET_EN
  bit m_btn;
  bit eq[$];        // raw button samples of the previous four edges, oldest first
`endif

  task automatic model_reset();
    m_ph = 0; m_el = 0; m_retry = 0;
    lq = '{1'b0, 1'b0};
`ifdef CRG_EXT_RESET_EN
    m_btn = 1'b0;
    eq = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
  endtask

  task automatic model_step();
    bit ls = lq[0];
    int nph = m_ph;
    bit bump = 1'b0;
    case (m_ph)
      0: if (m_el == PRC - 1) nph = 1;
      1: if (ls) nph = 2; else if (m_el == LT - 1) begin nph = 0; bump = 1'b1; end
      2: if (!ls) nph = 1; else if (m_el == LSC - 1) nph = 3;
      3: if (!ls) begin nph = 0; bump = 1'b1; end else if (m_el == HC - 1) nph = 4;
      4: begin
        if (!ls) begin nph = 0; bump = 1'b1; end
`ifdef CRG_EXT_RESET_EN
        else if (m_btn) nph = 5;
`endif
      end
`ifdef CRG_EXT_RESET_EN
      5: if (!ls) begin nph = 0; bump = 1'b1; end else if (!m_btn) nph = 3;
`endif
      default: nph = 0;
    endcase
    if (bump && m_retry < 15) m_retry++;
    if (nph != m_ph) m_el = 0; else m_el++;
    m_ph = nph;
    void'(lq.pop_front());
    lq.push_back(lock_pll);
`ifdef CRG_EXT_RESET_EN
    if (!eq[0] && !eq[1] && !eq[2]) m_btn = 1'b1;
    else if (eq[0] && eq[1] && eq[2]) m_btn = 1'b0;
    void'(eq.pop_front());
    eq.push_back(ext_reset_n);
`endif
  endtask

  function automatic logic [8:0] exp_vec();
    return {3'(m_ph), 4'(m_retry), (m_ph == 0), (m_ph != 4), (m_ph == 4)};
  endfunction

  logic [8:0] obs;
  assign obs = {state, retry_cnt, pll_areset, soc_reset, running};

  // One clock edge: advance the model with the sampled inputs, settle 1ns past the edge
  task automatic tick();
    @(posedge CLK12M);
    model_step();
    #1;
  endtask

  task automatic apply_reset(input bit lock_val);
    lock_pll = lock_val;
    reset = 1'b1;
    #1;
    model_reset();
    @(posedge CLK12M);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    lock_pll = 1'b0;
    model_reset();
    @(posedge CLK12M);
    #1;
    n_cmp++;
    if (obs !== 9'b000_0000_110) begin
      n_bad++;
      $display("FAIL reset_values: got %b want %b", obs, 9'b000_0000_110);
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if (obs !== exp_vec()) begin
      n_bad++;
      $display("FAIL reset_first_edge: got %b want %b", obs, exp_vec());
    end
  endtask

  task automatic test_startup();
    apply_reset(1'b0);
    for (int e = 1; e <= 70; e++) begin
      tick();
      if (e == 40) lock_pll = 1'b1;
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++;
        $display("FAIL startup_model edge %0d: got %b want %b", e, obs, exp_vec());
      end
      if (e == 15 || e == 16) begin
        n_cmp++;
        if (pll_areset !== (e == 15)) begin
          n_bad++;
          $display("FAIL startup_pll_areset edge %0d: got %b want %b", e, pll_areset, e == 15);
        end
      end
      if (e == 54 || e == 55) begin
        n_cmp++;
        if ({soc_reset, running, state} !== ((e == 54) ? 5'b1_0_011 : 5'b0_1_100)) begin
          n_bad++;
          $display("FAIL startup_release edge %0d: got %b want %b", e, {soc_reset, running, state},
                   (e == 54) ? 5'b1_0_011 : 5'b0_1_100);
        end
      end
    end
  endtask

  task automatic test_glitch();
    int fall_edge = -1;
    bit saw_stable = 1'b0, saw_restart = 1'b0;
    apply_reset(1'b1);
    for (int e = 1; e <= 45; e++) begin
      tick();
      if (e == 20) lock_pll = 1'b0;
      if (e == 21) lock_pll = 1'b1;
      if (state == 3'd2) saw_stable = 1'b1;
      if (saw_stable && state == 3'd1) saw_restart = 1'b1;
      if (fall_edge < 0 && soc_reset === 1'b0) fall_edge = e;
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++;
        $display("FAIL glitch_model edge %0d: got %b want %b", e, obs, exp_vec());
      end
    end
    n_cmp++;
    if (!saw_restart || fall_edge != 36 || retry_cnt !== 4'd0) begin
      n_bad++;
      $display("FAIL glitch_restart: got restart=%0b fall=%0d retry=%0d want restart=1 fall=36 retry=0",
               saw_restart, fall_edge, retry_cnt);
    end
  endtask

  task automatic test_timeout();
    apply_reset(1'b0);
    for (int e = 1; e <= 20 * (PRC + LT); e++) begin
      tick();
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++;
        $display("FAIL timeout_model edge %0d: got %b want %b", e, obs, exp_vec());
      end
      if (e == 115 || e == 116) begin
        n_cmp++;
        if ({pll_areset, retry_cnt} !== ((e == 115) ? 5'b0_0000 : 5'b1_0001)) begin
          n_bad++;
          $display("FAIL timeout_retry edge %0d: got %b want %b", e, {pll_areset, retry_cnt},
                   (e == 115) ? 5'b0_0000 : 5'b1_0001);
        end
      end
    end
    n_cmp++;
    if (retry_cnt !== 4'd15) begin
      n_bad++;
      $display("FAIL timeout_saturate: got %0d want 15", retry_cnt);
    end
  endtask

  task automatic test_lock_loss();
    int r0;
    bit reached = 1'b0;
    apply_reset(1'b1);
    for (int i = 0; i < 200 && !reached; i++) begin
      tick();
      reached = (m_ph == 4);
    end
    n_cmp++;
    if (!reached || running !== 1'b1) begin
      n_bad++;
      $display("FAIL lockloss_reach_run: got running=%b want 1 within 200 cycles", running);
    end
    r0 = m_retry;
    lock_pll = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++;
        $display("FAIL lockloss_model edge %0d: got %b want %b", e, obs, exp_vec());
      end
      if (e == 2 || e == 3) begin
        n_cmp++;
        if ({soc_reset, state} !== ((e == 2) ? 4'b0_100 : 4'b1_000)) begin
          n_bad++;
          $display("FAIL lockloss_latency edge %0d: got %b want %b", e, {soc_reset, state},
                   (e == 2) ? 4'b0_100 : 4'b1_000);
        end
      end
      if (e == 3) begin
        n_cmp++;
        if (retry_cnt !== 4'(r0 + 1)) begin
          n_bad++;
          $display("FAIL lockloss_retry: got %0d want %0d", retry_cnt, r0 + 1);
        end
      end
      if (e == 18 || e == 19) begin
        n_cmp++;
        if (pll_areset !== (e == 18)) begin
          n_bad++;
          $display("FAIL lockloss_pll_pulse edge %0d: got %b want %b", e, pll_areset, e == 18);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    bit reached = 1'b0;
    lock_pll = 1'b1;
    for (int i = 0; i < 200 && !reached; i++) begin
      tick();
      reached = (m_ph == 2);
    end
    n_cmp++;
    if (!reached || state !== 3'd2) begin
      n_bad++;
      $display("FAIL async_reach_stable: got state %0d want 2 within 200 cycles", state);
    end
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    n_cmp++;
    if (obs !== 9'b000_0000_110) begin
      n_bad++;
      $display("FAIL async_reset_immediate: got %b want %b", obs, 9'b000_0000_110);
    end
    @(posedge CLK12M);
    #1;
    reset = 1'b0;
    for (int e = 1; e <= 32; e++) begin
      tick();
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++;
        $display("FAIL async_rerun_model edge %0d: got %b want %b", e, obs, exp_vec());
      end
      if (e == 28 || e == 29) begin
        n_cmp++;
        if (soc_reset !== (e == 28)) begin
          n_bad++;
          $display("FAIL async_rerun_release edge %0d: got %b want %b", e, soc_reset, e == 28);
        end
      end
    end
  endtask

  task automatic test_random();
    apply_reset(1'b0);
    for (int seg = 0; seg < 120; seg++) begin
      int len;
      lock_pll = ($urandom_range(0, 2) != 0);
      if (lock_pll) len = $urandom_range(1, 50);
      else len = ($urandom_range(0, 5) == 0) ? $urandom_range(100, 130) : $urandom_range(1, 8);
      if ($urandom_range(0, 15) == 0) begin
        #($urandom_range(1, 7));
        reset = 1'b1;
        #1;
        model_reset();
        n_cmp++;
        if (obs !== exp_vec()) begin
          n_bad++;
          $display("FAIL random_async_reset seg %0d: got %b want %b", seg, obs, exp_vec());
        end
        @(posedge CLK12M);
        #1;
        reset = 1'b0;
      end
      for (int i = 0; i < len; i++) begin
        tick();
        n_cmp++;
        if (obs !== exp_vec()) begin
          n_bad++;
          $display("FAIL random_model seg %0d cyc %0d: got %b want %b", seg, i, obs, exp_vec());
        end
      end
    end
  endtask

`ifdef CRG_EXT_RESET_EN
  task automatic test_button();
    bit reached = 1'b0, saw_btn = 1'b0;
    apply_reset(1'b1);
    for (int i = 0; i < 200 && !reached; i++) begin
      tick();
      reached = (m_ph == 4);
    end
    n_cmp++;
    if (!reached || running !== 1'b1) begin
      n_bad++;
      $display("FAIL button_reach_run: got running=%b want 1", running);
    end
    ext_reset_n = 1'b0;
    for (int e = 1; e <= 30; e++) begin
      tick();
      if (e == 10) ext_reset_n = 1'b1;
      if (state == 3'd5 && soc_reset === 1'b1 && pll_areset === 1'b0) saw_btn = 1'b1;
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++;
        $display("FAIL button_model edge %0d: got %b want %b", e, obs, exp_vec());
      end
      if (e == 19 || e == 20) begin
        n_cmp++;
        if (state !== ((e == 19) ? 3'd3 : 3'd4)) begin
          n_bad++;
          $display("FAIL button_release edge %0d: got %0d want %0d", e, state, (e == 19) ? 3 : 4);
        end
      end
    end
    n_cmp++;
    if (!saw_btn || retry_cnt !== 4'd0) begin
      n_bad++;
      $display("FAIL button_hold: got seen=%0b retry=%0d want seen=1 retry=0", saw_btn, retry_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_startup();
    test_glitch();
    test_timeout();
    test_lock_loss();
    test_async_reset();
    test_random();
`ifdef CRG_EXT_RESET_EN
    test_button();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
